apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Command-to-APB bridge: takes single read/write requests over a valid/ready port and runs
//  the APB3 SETUP/ACCESS sequence against the downstream apb_slave register block.
//  Holds the transfer until the slave asserts pready, then returns read data and pslverr.
//  Sits upstream of apb_slave; the command side is driven by a test sequencer or control FSM.
// PARAMETERS
//  ADDR_W        32   width of cmd_addr / paddr
//  DATA_W        32   width of write/read data
//  TIMEOUT_CYC   16   max ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  pclk        in   1       clock, all logic on rising edge
//  preset      in   1       reset, asynchronous, active-high
//  cmd_valid   in   1       request present
//  cmd_ready   out  1       bridge accepts request (IDLE only)
//  cmd_write   in   1       1 = write, 0 = read
//  cmd_addr    in   ADDR_W  target address
//  cmd_wdata   in   DATA_W  write data
//  rsp_valid   out  1       response present; held until rsp_ready
//  rsp_ready   in   1       consumer takes response
//  rsp_rdata   out  DATA_W  read data (0 for writes)
//  rsp_err     out  1       pslverr sampled at completion, or timeout abort
//  psel        out  1       APB select
//  penable     out  1       APB enable
//  pwrite      out  1       APB direction
//  paddr       out  ADDR_W  APB address
//  pwdata      out  DATA_W  APB write data
//  pready      in   1       slave ready
//  pslverr     in   1       slave error
//  prdata      in   DATA_W  slave read data
// BEHAVIOUR
//  - All outputs registered. Reset (async, preset=1): state IDLE; psel, penable, pwrite,
//    rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0. cmd_ready = 1 only in IDLE (decoded from state).
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_valid & cmd_ready captures cmd_* into paddr/pwdata/pwrite; psel<=1, penable<=0; -> SETUP.
//  - SETUP: exactly one cycle; penable<=1; -> ACCESS. paddr/pwdata/pwrite stable from SETUP to end of ACCESS.
//  - ACCESS: wait states while pready=0, all APB outputs held. On pready=1: rsp_rdata<=pwrite?0:prdata,
//    rsp_err<=pslverr, psel<=0, penable<=0, rsp_valid<=1; -> RESP.
//  - RESP: rsp_valid held with stable data until rsp_ready=1; then rsp_valid<=0 -> IDLE.
//    rsp_ready while rsp_valid=0 ignored. New cmd never accepted in same cycle as response handshake.
//  - Minimum transaction: 3 cycles from accept to rsp_valid with zero wait states (pready in 1st ACCESS cycle).
//  - pslverr/prdata sampled only when psel & penable & pready; ignored otherwise.
//  - cmd_* changes while not in IDLE have no effect. Reset mid-transfer drops psel/penable immediately
//    (async) and discards the transfer; no response produced.
// CONFIGURATION
//  - APB_MASTER_TIMEOUT_EN defined: cycle counter cleared on entering ACCESS, increments per ACCESS cycle
//    with pready=0; at TIMEOUT_CYC wait cycles: abort, psel/penable<=0, rsp_err<=1, rsp_rdata<=0, -> RESP.
//    pready arriving on the abort cycle wins (normal completion).
//  - Not defined: no counter; ACCESS waits indefinitely for pready.
// STRUCTURE
//  - apb_master_pkg: state enum apb_mst_st_t {APB_M_IDLE, APB_M_SETUP, APB_M_ACCESS, APB_M_RESP}
//    (logic [1:0]), default width constants.
//  - Single module; timeout counter inline under the macro, no sub-module.
// TESTING
//  1 Write 0xDEADBEEF to 0x0, pready at 2nd ACCESS cycle -> psel 1 cycle before penable, rsp_valid with
//    rsp_err=0; then read 0x0 -> rsp_rdata=0xDEADBEEF.
//  2 Read 0x44 (unmapped) -> slave pslverr=1 -> rsp_err=1 on response.
//  3 Zero-wait slave (pready tied 1) -> rsp_valid exactly 3 cycles after cmd accept.
//  4 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, no APB activity.
//  5 preset pulsed during ACCESS -> psel/penable 0 same cycle, no rsp_valid, next cmd completes normally.
//  6 (APB_MASTER_TIMEOUT_EN) pready held 0 -> abort after 16 wait cycles, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_master_pkg.sv
//------------------------------------------------------------------------------
// Module  : apb_master_pkg
// Brief   : State encoding and default widths for the command-to-APB bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_master_pkg;

    typedef enum logic [1:0] {
        APB_M_IDLE   = 2'd0,
        APB_M_SETUP  = 2'd1,
        APB_M_ACCESS = 2'd2,
        APB_M_RESP   = 2'd3
    } apb_mst_st_t;

    localparam int c_ADDR_W_DEF      = 32;
    localparam int c_DATA_W_DEF      = 32;
    localparam int c_TIMEOUT_CYC_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module  : apb_master_bridge
// Brief   : Single-request valid/ready command port to APB3 master (SETUP/ACCESS).
//           Optional ACCESS timeout abort enabled by macro APB_MASTER_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEF,
    parameter int DATA_W      = c_DATA_W_DEF,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    apb_mst_st_t       r_state;
    apb_mst_st_t       w_next;
    logic              w_timeout;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYC must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Counts ACCESS cycles spent with pready low; abort lands on the last allowed one.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait_cnt <= '0;
        end else if (r_state == APB_M_SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == APB_M_ACCESS && !pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= APB_M_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            APB_M_IDLE:   if (cmd_valid) w_next = APB_M_SETUP;
            APB_M_SETUP:  w_next = APB_M_ACCESS;
            APB_M_ACCESS: if (pready || w_timeout) w_next = APB_M_RESP;
            APB_M_RESP:   if (rsp_ready) w_next = APB_M_IDLE;
            default:      w_next = APB_M_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                APB_M_IDLE: begin
                    if (cmd_valid) begin
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                        r_pwrite  <= cmd_write;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                    end
                end
                APB_M_SETUP: begin
                    r_penable <= 1'b1;
                end
                APB_M_ACCESS: begin
                    // A late pready on the abort cycle still counts as a normal completion.
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end
                end
                APB_M_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == APB_M_IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_apb_master_bridge
// Brief   : Directed self-checking bench for apb_master_bridge with a small
//           register-file APB slave (0x00-0x3C mapped, higher addresses error).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int compared   = 0;
    int mismatched = 0;

    apb_master_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave model: pready after wait_n stalled ACCESS cycles, or forced by tie1/hold0.
    logic [31:0] mem [0:15];
    logic [7:0]  acc_cnt;
    int          wait_n;
    logic        tie1;
    logic        hold0;
    logic        mapped;

    always_comb begin
        mapped  = (paddr < 32'h40);
        pready  = hold0 ? 1'b0 : (tie1 ? 1'b1 : (psel && penable && (int'(acc_cnt) >= wait_n)));
        prdata  = mapped ? mem[paddr[5:2]] : 32'hBAD0_BAD0;
        pslverr = psel && penable && !mapped;
    end

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            acc_cnt <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            acc_cnt <= (psel && penable && !pready) ? acc_cnt + 8'd1 : 8'd0;
            if (psel && penable && pready && pwrite && mapped)
                mem[paddr[5:2]] <= pwdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command from IDLE; n counts cycles from the accept cycle to rsp_valid.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int n);
        chk("txn_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 32'h5555_AAAA;
        n = 1;
        while (!rsp_valid && n < 64) begin
            @(posedge pclk); #1;
            n++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          n;

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; wait_n = 0; tie1 = 1'b0; hold0 = 1'b0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(posedge pclk); #1;
        chk("rst_psel",      {63'd0, psel},      64'd0);
        chk("rst_penable",   {63'd0, penable},   64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_paddr",     {32'd0, paddr},     64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);

        // Write 0xDEADBEEF to 0x0, pready on the second ACCESS cycle.
        wait_n = 1;
        cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'h0000_0ABC; cmd_wdata = 32'h1111_2222; cmd_write = 1'b0;
        chk("t1_setup_psel",    {63'd0, psel},      64'd1);
        chk("t1_setup_penable", {63'd0, penable},   64'd0);
        chk("t1_setup_ready",   {63'd0, cmd_ready}, 64'd0);
        chk("t1_setup_pwrite",  {63'd0, pwrite},    64'd1);
        chk("t1_setup_pwdata",  {32'd0, pwdata},    64'hDEAD_BEEF);
        @(posedge pclk); #1;
        chk("t1_acc1_penable",  {63'd0, penable},   64'd1);
        chk("t1_acc1_pready",   {63'd0, pready},    64'd0);
        @(posedge pclk); #1;
        chk("t1_acc2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t1_acc2_paddr",     {32'd0, paddr},     64'd0);
        chk("t1_acc2_pwdata",    {32'd0, pwdata},    64'hDEAD_BEEF);
        chk("t1_acc2_psel",      {63'd0, psel},      64'd1);
        @(posedge pclk); #1;
        chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t1_rsp_err",   {63'd0, rsp_err},   64'd0);
        chk("t1_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("t1_rsp_psel",  {63'd0, psel},      64'd0);
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        chk("t1_done_valid", {63'd0, rsp_valid}, 64'd0);
        do_txn(1'b0, 32'h0, 32'h0, rd, er, n);
        chk("t1_rd_data", {32'd0, rd}, 64'hDEAD_BEEF);
        chk("t1_rd_err",  {63'd0, er}, 64'd0);
        chk("t1_rd_lat",  64'(n),      64'd4);

        // Unmapped read and write raise pslverr.
        wait_n = 0;
        do_txn(1'b0, 32'h44, 32'h0, rd, er, n);
        chk("t2_rd_err", {63'd0, er}, 64'd1);
        do_txn(1'b1, 32'h40, 32'h7777_7777, rd, er, n);
        chk("t2_wr_err",   {63'd0, er}, 64'd1);
        chk("t2_wr_rdata", {32'd0, rd}, 64'd0);
        do_txn(1'b1, 32'h8, 32'h1234_5678, rd, er, n);
        chk("t2_wr8_err", {63'd0, er}, 64'd0);

        // Zero-wait slave: accept, SETUP, ACCESS, then response.
        tie1 = 1'b1;
        do_txn(1'b0, 32'h0, 32'h0, rd, er, n);
        chk("t3_lat",  64'(n),      64'd3);
        chk("t3_data", {32'd0, rd}, 64'hDEAD_BEEF);
        tie1 = 1'b0;

        // Back-pressured response holds; a pending command is not taken meanwhile.
        wait_n = 0;
        cmd_write = 1'b0; cmd_addr = 32'h8; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_addr = 32'h0;
        n = 0;
        while (!rsp_valid && n < 16) begin
            @(posedge pclk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t4_hold_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
            chk("t4_hold_ready", {63'd0, cmd_ready}, 64'd0);
            chk("t4_hold_psel",  {63'd0, psel},      64'd0);
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        chk("t4_hs_psel",  {63'd0, psel},      64'd0);
        chk("t4_hs_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t4_hs_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("t4_idle_psel", {63'd0, psel}, 64'd0);

        // Reset during ACCESS aborts the transfer with no response.
        wait_n = 5;
        cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFE_0001; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("t5_in_access", {63'd0, penable}, 64'd1);
        preset = 1'b1;
        #1;
        chk("t5_rst_psel",    {63'd0, psel},    64'd0);
        chk("t5_rst_penable", {63'd0, penable}, 64'd0);
        #1 preset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            if (rsp_valid) n++;
        end
        chk("t5_no_rsp",   64'(n),              64'd0);
        chk("t5_ready",    {63'd0, cmd_ready},  64'd1);
        wait_n = 0;
        do_txn(1'b1, 32'h10, 32'hCAFE_F00D, rd, er, n);
        chk("t5_wr_err", {63'd0, er}, 64'd0);
        do_txn(1'b0, 32'h10, 32'h0, rd, er, n);
        chk("t5_rd_data", {32'd0, rd}, 64'hCAFE_F00D);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never responds: abort on the 16th wait cycle.
        hold0 = 1'b1;
        do_txn(1'b0, 32'h10, 32'h0, rd, er, n);
        chk("t6_lat",   64'(n),      64'd18);
        chk("t6_err",   {63'd0, er}, 64'd1);
        chk("t6_rdata", {32'd0, rd}, 64'd0);
        hold0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
